// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, bit-timing helpers and parity,
// common to the receiver and the future transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned CPB_MIN   = 4;

    function automatic int unsigned calc_cpb(input logic [27:0] clock_freq,
                                             input logic [23:0] baud_rate);
        return 32'(clock_freq / {4'd0, baud_rate});
    endfunction

    function automatic int unsigned calc_half(input int unsigned cpb);
        return cpb / 32'd2;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned cpb);
        return (cpb > 32'd2) ? 32'($clog2(cpb)) : 32'd1;
    endfunction

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so an idle-high line does not look active after reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver delivering one-cycle rx_valid strobes per good byte.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter logic [23:0] BAUD_RATE  = 24'd4000000,
    parameter logic [27:0] CLOCK_FREQ = 28'd50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       parity_error,
    output logic       rx_busy
);

    localparam int unsigned CPB   = calc_cpb(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned HALF  = calc_half(CPB);
    localparam int unsigned CNT_W = calc_cnt_w(CPB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 32'd1);

    if (CPB < CPB_MIN) begin : g_cpb_check
        $error("uart_rx_frame: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

`ifdef UART_RX_PARITY_EN
    localparam uart_state_t ST_AFTER_DATA = ST_PARITY;
    logic parity_bad_r;
    logic parity_error_r;
    assign parity_error = parity_error_r;
`else
    localparam uart_state_t ST_AFTER_DATA = ST_STOP;
    assign parity_error = 1'b0;
`endif

    logic                 rx_s;
    uart_state_t          state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [7:0]           shift_r;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (uart_rx),
        .q     (rx_s)
    );

    // Frame FSM: start validation at mid-bit, data/parity/stop sampling, strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'd0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            rx_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_r   <= 1'b0;
            parity_error_r <= 1'b0;
`endif
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= {CNT_W{1'b0}};
                    bit_cnt_r <= 3'd0;
                    if (!rx_s) begin
                        state_r <= ST_START;
                        rx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_MID) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (!rx_s) begin
                            state_r <= ST_DATA;
                        end else begin
                            state_r <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        shift_r   <= {rx_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_AFTER_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r        <= {CNT_W{1'b0}};
                        parity_bad_r <= (rx_s != even_parity(shift_r));
                        state_r      <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (rx_s) begin
                            // Returning to IDLE half a bit early lets a back-to-back start bit be caught.
                            state_r <= ST_IDLE;
                            rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad_r) begin
                                parity_error_r <= 1'b1;
                            end else begin
                                rx_data  <= shift_r;
                                rx_valid <= 1'b1;
                            end
`else
                            rx_data  <= shift_r;
                            rx_valid <= 1'b1;
`endif
                        end else begin
                            frame_error <= 1'b1;
                            state_r     <= ST_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed, table-driven bench for uart_rx_frame at default bit timing (12 clocks/bit).
module tb_uart_rx_frame;

    localparam int CPB = 12;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Pin change (just before a posedge) to strobe visible: 3 sync/entry edges + HALF + 9*CPB (+CPB parity).
    localparam int LAT    = 3 + 6 + 9 * CPB + (NBITS - 10) * CPB;
    localparam int PERIOD = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       parity_error;
    logic       rx_busy;

    uart_rx_frame dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] v_data[$];
    int         v_time[$];
    int         fe_cnt = 0, pe_cnt = 0, wide_cnt = 0, excl_cnt = 0;
    logic       prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            v_data.push_back(rx_data);
            v_time.push_back(cyc);
        end
        if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
        if (parity_error === 1'b1) pe_cnt <= pe_cnt + 1;
        if ((rx_valid === 1'b1 && prev_v) || (frame_error === 1'b1 && prev_f) ||
            (parity_error === 1'b1 && prev_p))
            wide_cnt <= wide_cnt + 1;
        if (int'(rx_valid === 1'b1) + int'(frame_error === 1'b1) + int'(parity_error === 1'b1) > 1)
            excl_cnt <= excl_cnt + 1;
        prev_v <= (rx_valid === 1'b1);
        prev_f <= (frame_error === 1'b1);
        prev_p <= (parity_error === 1'b1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic bit_hold(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input int stop_low,
                              output int t_fall);
        t_fall = cyc;
        bit_hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        bit_hold((^d) ^ bad_par, CPB);
`endif
        if (stop_low > 0) bit_hold(1'b0, stop_low);
        bit_hold(1'b1, CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        int         stop_low;
        int         exp_v;
        logic [7:0] exp_data;
        int         exp_fe;
        int         exp_pe;
    } vec_t;

`ifdef UART_RX_PARITY_EN
    localparam int NV = 10;
`else
    localparam int NV = 8;
`endif
    vec_t vecs[NV];

    initial begin
        int tf, v0, fe0, pe0;

        vecs[0] = '{8'h3C, 1'b0, 0,  1, 8'h3C, 0, 0};
        vecs[1] = '{8'hA5, 1'b0, 0,  1, 8'hA5, 0, 0};
        vecs[2] = '{8'h00, 1'b0, 40, 0, 8'hA5, 1, 0};
        vecs[3] = '{8'h81, 1'b0, 0,  1, 8'h81, 0, 0};
        vecs[4] = '{8'hFF, 1'b0, 0,  1, 8'hFF, 0, 0};
        vecs[5] = '{8'h01, 1'b0, 0,  1, 8'h01, 0, 0};
        vecs[6] = '{8'h80, 1'b0, 0,  1, 8'h80, 0, 0};
        vecs[7] = '{8'h5A, 1'b0, 0,  1, 8'h5A, 0, 0};
`ifdef UART_RX_PARITY_EN
        vecs[8] = '{8'h07, 1'b0, 0,  1, 8'h07, 0, 0};
        vecs[9] = '{8'h07, 1'b1, 0,  0, 8'h07, 0, 1};
`endif

        uart_rx = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset rx_data", int'(rx_data), 0);
        chk("reset rx_valid", int'(rx_valid), 0);
        chk("reset frame_error", int'(frame_error), 0);
        chk("reset parity_error", int'(parity_error), 0);
        chk("reset rx_busy", int'(rx_busy), 0);
        bit_hold(1'b1, 10);

        // Short low glitch must be rejected at the start-bit midpoint.
        v0 = v_data.size(); fe0 = fe_cnt;
        bit_hold(1'b0, 3);
        bit_hold(1'b1, 20);
        chk("glitch no valid", v_data.size() - v0, 0);
        chk("glitch no frame_error", fe_cnt - fe0, 0);
        chk("glitch busy low", int'(rx_busy), 0);

        for (int k = 0; k < NV; k++) begin
            v0 = v_data.size(); fe0 = fe_cnt; pe0 = pe_cnt;
            send_frame(vecs[k].data, vecs[k].bad_par, vecs[k].stop_low, tf);
            bit_hold(1'b1, 30);
            chk($sformatf("vec%0d valid count", k), v_data.size() - v0, vecs[k].exp_v);
            chk($sformatf("vec%0d frame_error count", k), fe_cnt - fe0, vecs[k].exp_fe);
            chk($sformatf("vec%0d parity_error count", k), pe_cnt - pe0, vecs[k].exp_pe);
            chk($sformatf("vec%0d rx_data", k), int'(rx_data), int'(vecs[k].exp_data));
            chk($sformatf("vec%0d busy after", k), int'(rx_busy), 0);
            if (vecs[k].exp_v == 1 && v_data.size() == v0 + 1) begin
                chk($sformatf("vec%0d strobe data", k), int'(v_data[v0]), int'(vecs[k].exp_data));
                chk_rng($sformatf("vec%0d latency", k), v_time[v0] - tf, LAT - 1, LAT + 1);
            end
        end

        // Back-to-back frames with no idle gap.
        v0 = v_data.size();
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 0, tf);
        bit_hold(1'b1, 30);
        chk("b2b valid count", v_data.size() - v0, 16);
        for (int i = 0; i < 16; i++) begin
            if (v0 + i < v_data.size()) begin
                chk($sformatf("b2b data %0d", i), int'(v_data[v0 + i]), i);
                if (i > 0)
                    chk($sformatf("b2b spacing %0d", i), v_time[v0 + i] - v_time[v0 + i - 1], PERIOD);
            end
        end

        // Reset pulse during bit 4 of 0xFF aborts the frame.
        v0 = v_data.size(); fe0 = fe_cnt;
        bit_hold(1'b0, CPB);
        bit_hold(1'b1, 4 * CPB + 6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset rx_data", int'(rx_data), 0);
        chk("midreset rx_valid", int'(rx_valid), 0);
        chk("midreset frame_error", int'(frame_error), 0);
        chk("midreset parity_error", int'(parity_error), 0);
        chk("midreset rx_busy", int'(rx_busy), 0);
        bit_hold(1'b1, 6 + 3 * CPB + (NBITS - 9) * CPB + 30);
        chk("midreset no strobe", v_data.size() - v0, 0);
        chk("midreset no frame_error", fe_cnt - fe0, 0);
        send_frame(8'h5A, 1'b0, 0, tf);
        bit_hold(1'b1, 30);
        chk("after reset valid count", v_data.size() - v0, 1);
        chk("after reset rx_data", int'(rx_data), 8'h5A);

        chk("strobe width", wide_cnt, 0);
        chk("strobe exclusivity", excl_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
